// File: rtl/core_load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and word-addressed memory (slave).
interface core_load_store_unit_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_ack_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );
endinterface

// File: rtl/core_load_store_unit.sv
// RV32I load/store unit: alignment check, sub-word load extraction and
// read-modify-write sub-word stores over a req/ack word memory bus.
module core_load_store_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  busy_o,
    core_load_store_unit_if.master mem
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic [1:0]  state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    // Address bits above the memory size wrap away.
    logic unused_addr;
    assign unused_addr = ^addr_i[31:ADDR_WIDTH+2];

    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic illegal;
        logic misaligned;
        if (we) illegal = !(f3 == F_B || f3 == F_H || f3 == F_W);
        else    illegal = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        misaligned = (f3[1:0] == 2'b01 && lane[0]) || (f3[1:0] == 2'b10 && lane != 2'b00);
        return illegal || misaligned;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            F_B:     r = {{24{b[7]}}, b};
            F_BU:    r = {24'b0, b};
            F_H:     r = {{16{h[15]}}, h};
            F_HU:    r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [15:0] wd,
                                                input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        if (f3[0]) r[{lane[1], 4'b0000} +: 16] = wd;
        else       r[{lane, 3'b000} +: 8]      = wd[7:0];
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            we_q            <= 1'b0;
            funct3_q        <= 3'b0;
            lane_q          <= 2'b0;
            wdata_q         <= 16'b0;
            rdata_o         <= '0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            busy_o          <= 1'b0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_wdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: if (req_i) begin
                    we_q     <= we_i;
                    funct3_q <= funct3_i;
                    lane_q   <= addr_i[1:0];
                    wdata_q  <= wdata_i[15:0];
                    busy_o   <= 1'b1;
                    if (access_err(we_i, funct3_i, addr_i[1:0])) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                    end else begin
                        mem.mem_req_o  <= 1'b1;
                        mem.mem_addr_o <= addr_i[ADDR_WIDTH+1:2];
                        // A full-word store skips the read; sub-word stores read first.
                        if (we_i && funct3_i == F_W) begin
                            mem.mem_we_o    <= 1'b1;
                            mem.mem_wdata_o <= wdata_i;
                            state           <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: if (mem.mem_ack_i) begin
                    if (we_q) begin
                        mem.mem_wdata_o <= store_merge(mem.mem_rdata_i, wdata_q, funct3_q, lane_q);
                        mem.mem_we_o    <= 1'b1;
                        state           <= WR;
                    end else begin
                        rdata_o       <= load_extract(mem.mem_rdata_i, funct3_q, lane_q);
                        mem.mem_req_o <= 1'b0;
                        done_o        <= 1'b1;
                        state         <= DONE;
                    end
                end
                WR: if (mem.mem_ack_i) begin
                    mem.mem_req_o <= 1'b0;
                    mem.mem_we_o  <= 1'b0;
                    done_o        <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_load_store_unit.sv
// Directed bench for core_load_store_unit with a behavioural word memory
// that can insert wait states before acknowledging.
module tb_core_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i, we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] rdata_o;
    logic        done_o, err_o, busy_o;

    core_load_store_unit_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) mem_if ();

    core_load_store_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .we_i     (we_i),
        .funct3_i (funct3_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .busy_o   (busy_o),
        .mem      (mem_if.master)
    );

    always #5 clk = ~clk;

    // Memory model: stall_load wait cycles at the start of each request burst.
    logic [31:0] mem [0:1023];
    int          stall_load;
    int          stall_cnt;
    int          reads_cnt;
    int          writes_cnt;
    logic        bd_en;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;

    assign mem_if.mem_ack_i   = mem_if.mem_req_o && (stall_cnt == 0);
    assign mem_if.mem_rdata_i = mem[mem_if.mem_addr_o];

    initial begin
        stall_cnt  = 0;
        reads_cnt  = 0;
        writes_cnt = 0;
    end

    always @(posedge clk) begin
        if (!mem_if.mem_req_o)  stall_cnt <= stall_load;
        else if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
        if (bd_en) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_if.mem_req_o && mem_if.mem_ack_i) begin
            if (mem_if.mem_we_o) begin
                mem[mem_if.mem_addr_o] <= mem_if.mem_wdata_o;
                writes_cnt <= writes_cnt + 1;
            end else begin
                reads_cnt <= reads_cnt + 1;
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bd_en   = 1'b0;
    endtask

    int         lat;
    logic       err_seen, saw_req, addr_ok, busy_ok, done_after, busy_after;
    logic [9:0] req_addr;
    int         rd0, wr0;

    // Called at a negedge; the next rising edge is counted as edge T.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic hold_next);
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
        lat = 0; err_seen = 1'b0; saw_req = 1'b0; addr_ok = 1'b1; busy_ok = 1'b1;
        req_addr = '0;
        rd0 = reads_cnt; wr0 = writes_cnt;
        @(posedge clk);
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (mem_if.mem_req_o) begin
                if (!saw_req) begin
                    saw_req  = 1'b1;
                    req_addr = mem_if.mem_addr_o;
                end else if (mem_if.mem_addr_o !== req_addr) begin
                    addr_ok = 1'b0;
                end
            end
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            if (done_o === 1'b1) begin
                lat      = n;
                err_seen = err_o;
            end
        end
        if (!hold_next) begin
            req_i = 1'b0;
            @(negedge clk);
            done_after = done_o;
            busy_after = busy_o;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic rst_done_seen;

    initial begin
        rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b0;
        addr_i = '0; wdata_i = '0; bd_en = 1'b0; bd_addr = '0; bd_data = '0;
        stall_load = 0;
        repeat (2) @(negedge clk);

        check("rst_outputs", {rdata_o[7:0], 20'b0, done_o, err_o, busy_o, mem_if.mem_req_o},
              32'h0);
        check("rst_mem_bus", {mem_if.mem_we_o, mem_if.mem_addr_o, mem_if.mem_wdata_o[20:0]},
              32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        rst_n = 1'b1;

        poke(10'd2, 32'hDEADBEEF);
        poke(10'd1, 32'h11223344);
        poke(10'd8, 32'h00000000);

        // LW at 0x08, immediate ack
        do_req(1'b0, 3'b010, 32'h08, 32'h0, 1'b0);
        check("lw_lat", lat, 2);
        check("lw_rdata", rdata_o, 32'hDEADBEEF);
        check("lw_err", 32'(err_seen), 0);
        check("lw_addr", 32'(req_addr), 2);
        check("lw_busy", 32'(busy_ok), 1);
        check("lw_reads", reads_cnt - rd0, 1);
        check("lw_done_once", 32'(done_after), 0);
        check("lw_busy_after", 32'(busy_after), 0);

        poke(10'd2, 32'h80FF7F01);
        do_req(1'b0, 3'b000, 32'h0B, 32'h0, 1'b0);
        check("lb_rdata", rdata_o, 32'hFFFFFF80);
        check("lb_lat", lat, 2);
        do_req(1'b0, 3'b100, 32'h0B, 32'h0, 1'b0);
        check("lbu_rdata", rdata_o, 32'h00000080);
        do_req(1'b0, 3'b001, 32'h0A, 32'h0, 1'b0);
        check("lh_rdata", rdata_o, 32'hFFFF80FF);
        do_req(1'b0, 3'b101, 32'h0A, 32'h0, 1'b0);
        check("lhu_rdata", rdata_o, 32'h000080FF);
        do_req(1'b0, 3'b100, 32'h08, 32'h0, 1'b0);
        check("lbu0_rdata", rdata_o, 32'h00000001);
        do_req(1'b0, 3'b000, 32'h09, 32'h0, 1'b0);
        check("lb1_rdata", rdata_o, 32'h0000007F);

        // SB at 0x05 onto 0x11223344
        do_req(1'b1, 3'b000, 32'h05, 32'h000000AA, 1'b0);
        check("sb_lat", lat, 3);
        check("sb_mem", mem[1], 32'h1122AA44);
        check("sb_reads", reads_cnt - rd0, 1);
        check("sb_writes", writes_cnt - wr0, 1);
        check("sb_rdata_kept", rdata_o, 32'h0000007F);
        check("sb_err", 32'(err_seen), 0);

        // SH at 0x06 replaces upper half
        do_req(1'b1, 3'b001, 32'h06, 32'h1234BEEF, 1'b0);
        check("sh_lat", lat, 3);
        check("sh_mem", mem[1], 32'hBEEFAA44);

        // SW at 0x14: write only
        do_req(1'b1, 3'b010, 32'h14, 32'h55667788, 1'b0);
        check("sw_lat", lat, 2);
        check("sw_mem", mem[5], 32'h55667788);
        check("sw_reads", reads_cnt - rd0, 0);
        check("sw_writes", writes_cnt - wr0, 1);

        // Error responses: no memory traffic, rdata untouched
        do_req(1'b1, 3'b001, 32'h03, 32'h0, 1'b0);
        check("sh_mis_lat", lat, 1);
        check("sh_mis_err", 32'(err_seen), 1);
        check("sh_mis_noreq", 32'(saw_req), 0);
        check("sh_mis_rdata", rdata_o, 32'h0000007F);
        check("sh_mis_done_once", 32'(done_after), 0);
        do_req(1'b0, 3'b011, 32'h00, 32'h0, 1'b0);
        check("ld011_lat", lat, 1);
        check("ld011_err", 32'(err_seen), 1);
        check("ld011_noreq", 32'(saw_req), 0);
        do_req(1'b0, 3'b010, 32'h02, 32'h0, 1'b0);
        check("lw_mis_err", 32'(err_seen), 1);
        check("lw_mis_lat", lat, 1);
        do_req(1'b1, 3'b100, 32'h00, 32'h0, 1'b0);
        check("st100_err", 32'(err_seen), 1);
        check("st100_noreq", 32'(saw_req), 0);
        do_req(1'b0, 3'b101, 32'h01, 32'h0, 1'b0);
        check("lhu_mis_err", 32'(err_seen), 1);

        // LW with 4 wait states
        stall_load = 4;
        do_req(1'b0, 3'b010, 32'h14, 32'h0, 1'b0);
        stall_load = 0;
        check("lw_wait_lat", lat, 6);
        check("lw_wait_addr_stable", 32'(addr_ok), 1);
        check("lw_wait_addr", 32'(req_addr), 5);
        check("lw_wait_busy", 32'(busy_ok), 1);
        check("lw_wait_rdata", rdata_o, 32'h55667788);
        check("lw_wait_done_once", 32'(done_after), 0);

        // Back-to-back loads: the second request waits out the DONE cycle
        do_req(1'b0, 3'b010, 32'h08, 32'h0, 1'b1);
        check("b2b_first_lat", lat, 2);
        do_req(1'b0, 3'b010, 32'h14, 32'h0, 1'b0);
        check("b2b_second_lat", lat, 3);
        check("b2b_rdata", rdata_o, 32'h55667788);

        // Reset while WR waits for ack
        stall_load = 100;
        rd0 = reads_cnt; wr0 = writes_cnt;
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h20; wdata_i = 32'hA5A5A5A5;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("rstmid_in_wr", {30'b0, mem_if.mem_req_o, mem_if.mem_we_o}, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_req_drop", 32'(mem_if.mem_req_o), 0);
        check("rstmid_busy_drop", 32'(busy_o), 0);
        req_i = 1'b0;
        stall_load = 0;
        rst_done_seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done_o !== 1'b0) rst_done_seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            if (done_o !== 1'b0) rst_done_seen = 1'b1;
        end
        check("rstmid_no_done", 32'(rst_done_seen), 0);
        check("rstmid_no_write", writes_cnt - wr0, 0);
        check("rstmid_mem_kept", mem[8], 32'h0);
        check("rstmid_rdata_clr", rdata_o, 32'h0);

        // LW at 0x1008 wraps to word 2
        do_req(1'b0, 3'b010, 32'h1008, 32'h0, 1'b0);
        check("post_rst_lat", lat, 2);
        check("post_rst_addr", 32'(req_addr), 2);
        check("post_rst_rdata", rdata_o, 32'h80FF7F01);
        check("post_rst_err", 32'(err_seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
